// File: rtl/rb_cnt_seq_if.sv
// rb_cnt_seq_if: request/result bundle for the row-serial Othello piece counter.
// The master side issues start with the two occupancy boards; the slave side
// (the counter) returns busy/done, the three counts, the lead code and overlap.
interface rb_cnt_seq_if #(
  parameter int SIDE  = 8,
  parameter int CNT_W = 8
);
  logic                   start;
  logic [SIDE*SIDE-1:0]   B;
  logic [SIDE*SIDE-1:0]   R;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       cntB;
  logic [CNT_W-1:0]       cntR;
  logic [CNT_W-1:0]       cntE;
  logic [1:0]             lead;
  logic                   overlap;

  modport master (
    output start, B, R,
    input  busy, done, cntB, cntR, cntE, lead, overlap
  );

  modport slave (
    input  start, B, R,
    output busy, done, cntB, cntR, cntE, lead, overlap
  );
endinterface

// File: rtl/rb_cnt_seq.sv
// rb_cnt_seq: row-serial Blue/Red/empty piece counter for an SIDE x SIDE board.
// A start pulse snapshots both boards; one row is summed per clock and the
// results, lead code and done pulse appear SIDE cycles after the start edge.
// Optional feature macro: RB_CNT_OVERLAP_CHK_EN (builds the B&R overlap flag;
// when undefined, overlap is tied to 0).
module rb_cnt_seq #(
  parameter int SIDE  = 8,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         RST,
  rb_cnt_seq_if.slave  bus
);

  localparam int N     = SIDE * SIDE;
  localparam int IDX_W = (SIDE > 1) ? $clog2(SIDE) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     shadow_b, shadow_r;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc_b, acc_r, acc_e;
  logic [CNT_W-1:0] sum_b, sum_r, sum_e;
  logic [CNT_W-1:0] cnt_b, cnt_r, cnt_e;
  logic [1:0]       lead;
  logic             done;
  logic [SIDE-1:0]  row_b, row_r;
  logic             accept, finish, last_row;

  // Number of set bits in one row, already widened to the count width.
  function automatic logic [CNT_W-1:0] popcnt(input logic [SIDE-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < SIDE; i++) begin
      s = s + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return s;
  endfunction

  // Lead code: 01 Blue ahead, 10 Red ahead, 00 tie.
  function automatic logic [1:0] lead_of(input logic [CNT_W-1:0] b,
                                         input logic [CNT_W-1:0] r);
    if (b > r) return 2'b01;
    if (r > b) return 2'b10;
    return 2'b00;
  endfunction

  // Select the row currently being summed and form the running totals.
  always_comb begin
    row_b    = shadow_b[int'(idx)*SIDE +: SIDE];
    row_r    = shadow_r[int'(idx)*SIDE +: SIDE];
    sum_b    = acc_b + popcnt(row_b);
    sum_r    = acc_r + popcnt(row_r);
    sum_e    = acc_e + popcnt(~(row_b | row_r));
    last_row = (idx == IDX_W'(SIDE - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE, so a start while
  // scanning is simply dropped.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (last_row) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, row accumulation and result update; results only move on finish.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      shadow_b <= '0;
      shadow_r <= '0;
      idx      <= '0;
      acc_b    <= '0;
      acc_r    <= '0;
      acc_e    <= '0;
      cnt_b    <= '0;
      cnt_r    <= '0;
      cnt_e    <= '0;
      lead     <= 2'b00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shadow_b <= bus.B;
        shadow_r <= bus.R;
        idx      <= '0;
        acc_b    <= '0;
        acc_r    <= '0;
        acc_e    <= '0;
      end else if (state == SCAN) begin
        acc_b <= sum_b;
        acc_r <= sum_r;
        acc_e <= sum_e;
        idx   <= idx + 1'b1;
        if (finish) begin
          cnt_b <= sum_b;
          cnt_r <= sum_r;
          cnt_e <= sum_e;
          lead  <= lead_of(sum_b, sum_r);
          done  <= 1'b1;
        end
      end
    end
  end

`ifdef RB_CNT_OVERLAP_CHK_EN
  logic ov_flag, ov_out, row_ov;
  assign row_ov = |(row_b & row_r);

  // Sticky overlap flag over the scan, published together with the counts.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ov_flag <= 1'b0;
      ov_out  <= 1'b0;
    end else if (accept) begin
      ov_flag <= 1'b0;
    end else if (state == SCAN) begin
      ov_flag <= ov_flag | row_ov;
      if (finish) ov_out <= ov_flag | row_ov;
    end
  end

  assign bus.overlap = ov_out;
`else
  assign bus.overlap = 1'b0;
`endif

  assign bus.busy = (state == SCAN);
  assign bus.done = done;
  assign bus.cntB = cnt_b;
  assign bus.cntR = cnt_r;
  assign bus.cntE = cnt_e;
  assign bus.lead = lead;

endmodule

// File: doc/rb_cnt_seq.md
Name: rb_cnt_seq

Overview:
Parametrised, row-serial piece counter for the Othello board. On a start pulse it snapshots the Blue (B) and Red (R) occupancy boards, then scans one row per clock. It produces the B, R and empty-square counts and a lead indicator, with a start/busy/done handshake. It sits between the board state registers and the score display / game-over logic. It replaces the single-cycle flat adder tree, which does not scale to larger boards.

Parameters:
SIDE, 8, board side length; board holds SIDE*SIDE squares; legal range 2..16
CNT_W, 8, width of every count output; must be >= clog2(SIDE*SIDE+1)

Ports:
clk  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
start  in  1  request a count; sampled on rising clk
B  in  SIDE*SIDE  Blue occupancy; bit r*SIDE+c is row r, column c
R  in  SIDE*SIDE  Red occupancy; same bit mapping as B
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse when the result outputs update
cntB  out  CNT_W  number of set bits in B
cntR  out  CNT_W  number of set bits in R
cntE  out  CNT_W  number of squares with neither B nor R set
lead  out  2  00 tie, 01 B ahead, 10 R ahead; 11 never driven
overlap  out  1  some square has both B and R set (see Optional Feature)

Behaviour:
- Reset:
  - clk is the only clock; RST is asynchronous and active-low.
  - While RST=0: state=IDLE; busy, done, cntB, cntR, cntE, lead and overlap all 0; shadow boards, row index and accumulators cleared.
  - RST asserted mid-scan aborts the scan with no done pulse. Result outputs go to 0.
- FSM states: IDLE and SCAN.
- IDLE:
  - On start=1: latch B and R into shadow registers, clear accumulators, row index=0, go to SCAN, busy=1.
- SCAN, one row per cycle:
  - Add popcount(shadowB row idx), popcount(shadowR row idx) and popcount(~(shadowB|shadowR) row idx) to accB, accR and accE. Then idx++.
  - On the edge that processes row SIDE-1:
    - load cntB/cntR/cntE with the final sums, including that row;
    - update lead;
    - done=1 for exactly that cycle;
    - busy=0; return to IDLE.
- Latency: start sampled at edge k gives done=1 and new results after edge k+SIDE, i.e. SIDE cycles.
- Input stability: changes on B/R after the start edge do not affect the running result.
- Output hold: result outputs hold their previous values throughout SCAN and change only on the done cycle.
- start while busy=1 is ignored, with no queueing.
- start high in the same cycle done=1 is accepted, since the FSM is already IDLE. Back-to-back counts therefore run every SIDE cycles.
- start held high continuously re-triggers at every IDLE cycle.
- Arithmetic: unsigned, widened to CNT_W before accumulation; no saturation is needed given the CNT_W rule.
  - A square set in both B and R counts in both cntB and cntR, and not in cntE.
  - Invariant when no overlap exists: cntB+cntR+cntE = SIDE*SIDE.
- lead compares the final cntB and cntR; equal gives 00.

Optional Feature:
RB_CNT_OVERLAP_CHK_EN
- Defined: during SCAN a sticky flag ORs in any row with (shadowB & shadowR) != 0.
  - overlap is loaded from this flag on the done cycle and holds until the next done or reset.
  - The flag clears when start is accepted.
- Undefined: no overlap logic is built and overlap is tied to 0. Counting behaviour is identical in both cases.

Test Plan:
1. SIDE=8, opening position (B bits 28,35; R bits 27,36), start 1 cycle -> busy 8 cycles; done exactly 8 cycles after the start edge; cntB=2, cntR=2, cntE=60, lead=00.
2. B=all ones, R=0 -> cntB=64, cntR=0, cntE=0, lead=01. Then B=0, R=all ones -> cntR=64, lead=10. Counts must not wrap at 64.
3. Protocol robustness:
   - Start, then change B to all ones and pulse start again at cycles 3 and 5 of the scan -> a single done and the original snapshot result.
   - Next start issued in the done cycle -> second done 8 cycles later.
4. Assert RST at scan cycle 4 -> all outputs 0 immediately (asynchronous, before the next clk edge); no done pulse; a subsequent start yields a correct full count.
5. With RB_CNT_OVERLAP_CHK_EN defined: B bit 63 and R bit 63 both set plus B bit 0 -> cntB=2, cntR=1, cntE=62, overlap=1. Next count with no overlap -> overlap=0. With the macro undefined, overlap stays 0.
6. SIDE=4, CNT_W=5, B=0xFFFF, R=0 -> done after 4 cycles, cntB=16, cntE=0, lead=01.
